fp32_add_pipe: RTL and testbench

//  Pipelined IEEE-754 single-precision adder. Consumes the op_a/op_b operand pair driven by the
//  PE operand-select mux: either (activation, weight) or (residual, 32'h3F800000 = 1.0f).

---
 rtl/fp32_add_pipe.sv | 221 ++++++++++++++++++++++
 tb/tb_fp32_add_pipe.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_add_pipe.sv
// fp32_add_pipe -- three-stage pipelined IEEE-754 single-precision adder.
//
// Takes operand pairs from the PE operand-select mux and hands the sum to the
// PE accumulator/writeback under valid/ready flow control. Latency is three
// cycles when not stalled: operands accepted in cycle 0 appear on sum in
// cycle 3. The whole pipe advances as one unit; bubbles are not collapsed.
//
// Subnormal inputs and results are flushed to signed zero. NaN results are
// always emitted as CANON_NAN.
//
// Build option:
//   FP32_ADD_RNE_EN  defined   -> round to nearest, ties to even; overflow
//                                 gives +/-inf with ovf=1.
//                    undefined -> truncate toward zero; overflow saturates to
//                                 +/-7F7FFFFF with ovf=1.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   op_a/op_b valid this cycle
//   in_ready   adder accepts operands this cycle (combinational from out_ready)
//   op_a/op_b  FP32 operands
//   out_valid  sum/ovf/invalid valid
//   out_ready  downstream accepts the sum
//   sum        FP32 result
//   ovf        finite inputs overflowed to the largest magnitude / inf
//   invalid    result is NaN (NaN input or inf + -inf)
module fp32_add_pipe #(
  parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] sum,
  output logic        ovf,
  output logic        invalid
);

  localparam int STAGES = 3;

  // Mantissas carry 24 significant bits plus guard/round/sticky.
  typedef struct packed {
    logic        sgn;       // sign of the larger-magnitude operand
    logic [7:0]  exp;       // biased exponent of the larger operand
    logic [26:0] big;
    logic [26:0] sml;       // aligned, sticky folded into bit 0
    logic        sub;       // effective subtraction
    logic        both_neg;  // (-0)+(-0) keeps its sign
    logic        spec;      // special result decided up front
    logic        inv;
    logic [31:0] sval;
  } s1_t;

  typedef struct packed {
    logic        sgn;
    logic [7:0]  exp;
    logic [27:0] sum;
    logic        both_neg;
    logic        spec;
    logic        inv;
    logic [31:0] sval;
  } s2_t;

  logic [STAGES:1] vld_pipe;
  logic            adv;
  s1_t             s1_q, s1_n;
  s2_t             s2_q, s2_n;
  logic [31:0]     res;
  logic            res_ovf, res_inv;

  assign out_valid = vld_pipe[STAGES];
  assign adv       = ~vld_pipe[STAGES] | out_ready;
  assign in_ready  = adv;

  // Position of the leading one counted from bit 26; 27 for an all-zero word.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) lzc27 = 5'(26 - i);
  endfunction

  // ---------------- S1: unpack, specials, swap, align ----------------
  logic        a_nan, b_nan, a_inf, b_inf, swap;
  logic [30:0] a_mag, b_mag, big_mag, sml_mag;
  logic [7:0]  d;
  logic [4:0]  dsh;
  logic [26:0] sml_m;
  logic [53:0] sml_wide;

  always_comb begin
    a_nan    = (op_a[30:23] == 8'hFF) & (op_a[22:0] != 23'd0);
    b_nan    = (op_b[30:23] == 8'hFF) & (op_b[22:0] != 23'd0);
    a_inf    = (op_a[30:23] == 8'hFF) & (op_a[22:0] == 23'd0);
    b_inf    = (op_b[30:23] == 8'hFF) & (op_b[22:0] == 23'd0);
    // Exponent 0 covers zero and subnormal: both become a (signed) zero.
    a_mag    = (op_a[30:23] == 8'h00) ? 31'd0 : op_a[30:0];
    b_mag    = (op_b[30:23] == 8'h00) ? 31'd0 : op_b[30:0];
    swap     = b_mag > a_mag;
    big_mag  = swap ? b_mag : a_mag;
    sml_mag  = swap ? a_mag : b_mag;
    d        = big_mag[30:23] - sml_mag[30:23];
    dsh      = (d >= 8'd27) ? 5'd27 : d[4:0];
    sml_m    = {(sml_mag[30:23] != 8'h00), sml_mag[22:0], 3'b000};
    // Shift into a double-width word so the shifted-out bits land in the
    // low half; with a shift of 27 the whole operand collapses to sticky.
    sml_wide = {sml_m, 27'd0} >> dsh;

    s1_n          = '0;
    s1_n.sgn      = swap ? op_b[31] : op_a[31];
    s1_n.exp      = big_mag[30:23];
    s1_n.big      = {(big_mag[30:23] != 8'h00), big_mag[22:0], 3'b000};
    s1_n.sml      = sml_wide[53:27] | {26'd0, |sml_wide[26:0]};
    s1_n.sub      = op_a[31] ^ op_b[31];
    s1_n.both_neg = op_a[31] & op_b[31];
    if (a_nan | b_nan | (a_inf & b_inf & (op_a[31] ^ op_b[31]))) begin
      s1_n.spec = 1'b1;
      s1_n.inv  = 1'b1;
      s1_n.sval = CANON_NAN;
    end else if (a_inf) begin
      s1_n.spec = 1'b1;
      s1_n.sval = op_a;
    end else if (b_inf) begin
      s1_n.spec = 1'b1;
      s1_n.sval = op_b;
    end
  end

  // ---------------- S2: add / subtract ----------------
  // After the swap big >= sml, so the difference never goes negative.
  always_comb begin
    s2_n          = '0;
    s2_n.sgn      = s1_q.sgn;
    s2_n.exp      = s1_q.exp;
    s2_n.sum      = s1_q.sub ? ({1'b0, s1_q.big} - {1'b0, s1_q.sml})
                             : ({1'b0, s1_q.big} + {1'b0, s1_q.sml});
    s2_n.both_neg = s1_q.both_neg;
    s2_n.spec     = s1_q.spec;
    s2_n.inv      = s1_q.inv;
    s2_n.sval     = s1_q.sval;
  end

  // ---------------- S3: normalize, round, pack ----------------
  logic [4:0]        lz;
  logic [26:0]       n_mant;   // bit 26 = hidden one, [2:0] = G/R/S
  logic signed [9:0] n_exp, f_exp;
  logic [2:0]        inc;
  logic [24:0]       r_mant;
  logic [22:0]       f_frac;

  always_comb begin
    lz = lzc27(s2_q.sum[26:0]);
    if (s2_q.sum[27]) begin
      // Carry out: shift right one, keeping the dropped bit as sticky.
      n_mant = {s2_q.sum[27:2], s2_q.sum[1] | s2_q.sum[0]};
      n_exp  = $signed({2'b00, s2_q.exp}) + 10'sd1;
    end else begin
      n_mant = s2_q.sum[26:0] << lz;
      n_exp  = $signed({2'b00, s2_q.exp}) - $signed({5'd0, lz});
    end

`ifdef FP32_ADD_RNE_EN
    // Adding 011 (+1 when the kept LSB is odd) below the LSB carries into
    // the mantissa exactly when RNE rounds up.
    inc = n_mant[3] ? 3'b100 : 3'b011;
`else
    inc = 3'b000;
`endif
    r_mant = 25'(({1'b0, n_mant} + {25'd0, inc}) >> 3);
    // A rounding carry leaves 1.000..0, so renormalizing is one shift.
    f_exp  = r_mant[24] ? n_exp + 10'sd1 : n_exp;
    f_frac = r_mant[24] ? r_mant[23:1] : r_mant[22:0];

    res     = '0;
    res_ovf = 1'b0;
    res_inv = 1'b0;
    if (s2_q.spec) begin
      res     = s2_q.sval;
      res_inv = s2_q.inv;
    end else if (s2_q.sum == 28'd0) begin
      // Exact cancellation is +0; only (-0)+(-0) stays negative.
      res = {s2_q.both_neg, 31'd0};
    end else if (f_exp >= 10'sd255) begin
      res_ovf = 1'b1;
`ifdef FP32_ADD_RNE_EN
      res     = {s2_q.sgn, 8'hFF, 23'd0};
`else
      res     = {s2_q.sgn, 31'h7F7FFFFF};
`endif
    end else if (f_exp <= 10'sd0) begin
      res = {s2_q.sgn, 31'd0};
    end else begin
      res = {s2_q.sgn, f_exp[7:0], f_frac};
    end
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      sum      <= '0;
      ovf      <= 1'b0;
      invalid  <= 1'b0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      s1_q     <= s1_n;
      s2_q     <= s2_n;
      // Bubbles reaching the output drive zeros rather than stale data.
      sum      <= vld_pipe[STAGES-1] ? res     : 32'd0;
      ovf      <= vld_pipe[STAGES-1] ? res_ovf : 1'b0;
      invalid  <= vld_pipe[STAGES-1] ? res_inv : 1'b0;
    end
  end

endmodule

// File: tb/tb_fp32_add_pipe.sv
// Testbench for fp32_add_pipe: directed cases with fixed expected values,
// a stall/back-pressure stream, a randomized stream checked against an exact
// wide-integer reference model, and a mid-flight reset.
`timescale 1ns/1ps
module tb_fp32_add_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op_a = '0, op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] sum;
  logic        ovf, invalid;

  int          n_chk = 0, n_err = 0;
  logic [33:0] exp_q[$];
  logic [33:0] got_q[$];
  logic [31:0] held, ra, rb;
  logic        seen, done;

  always #5 clk = ~clk;

  fp32_add_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .ovf(ovf), .invalid(invalid)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Exact reference: each operand becomes an integer in units of 2^-149,
  // the sum is exact, then it is rounded back to FP32.
  function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic         an, bn, ai, bi, s;
    logic [299:0] va, vb, mag, tmp;
`ifdef FP32_ADD_RNE_EN
    logic [299:0] rem, half;
`endif
    logic [24:0]  m;
    int           p, sh, e;
    an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    if (an || bn || (ai && bi && (a[31] != b[31]))) return {32'h7FC00000, 2'b01};
    if (ai) return {a, 2'b00};
    if (bi) return {b, 2'b00};
    va = (a[30:23] == 0) ? '0 : ({276'd0, 1'b1, a[22:0]} << (int'(a[30:23]) - 1));
    vb = (b[30:23] == 0) ? '0 : ({276'd0, 1'b1, b[22:0]} << (int'(b[30:23]) - 1));
    if (a[31] == b[31]) begin mag = va + vb; s = a[31]; end
    else if (va >= vb)  begin mag = va - vb; s = a[31]; end
    else                begin mag = vb - va; s = b[31]; end
    if (mag == 0) return {a[31] & b[31], 31'd0, 2'b00};
    p = 0;
    for (int i = 299; i >= 0; i--) if (mag[i]) begin p = i; break; end
    e = p - 22;
    if (e <= 0) return {s, 31'd0, 2'b00};
    sh  = p - 23;
    tmp = mag >> sh;
    m   = {1'b0, tmp[23:0]};
`ifdef FP32_ADD_RNE_EN
    rem = mag & ((300'd1 << sh) - 300'd1);
    if (sh > 0) begin
      half = 300'd1 << (sh - 1);
      if (rem > half || (rem == half && m[0])) m = m + 25'd1;
    end
`endif
    if (m[24]) begin m = m >> 1; e++; end
    if (e >= 255) begin
`ifdef FP32_ADD_RNE_EN
      return {s, 8'hFF, 23'd0, 2'b10};
`else
      return {s, 31'h7F7FFFFF, 2'b10};
`endif
    end
    return {s, 8'(e), m[22:0], 2'b00};
  endfunction

  // Random operand with a mix of classes; some are placed near the
  // reference operand's exponent or are its negation to force cancellation.
  function automatic logic [31:0] rnd_fp(input logic [31:0] r);
    int          k, ee;
    logic        s;
    logic [22:0] f;
    k  = $urandom_range(0, 19);
    s  = 1'($urandom_range(0, 1));
    f  = 23'($urandom);
    ee = $urandom_range(1, 254);
    case (k)
      0: return {s, 31'd0};
      1: return {s, 8'h00, f};
      2: return {s, 8'hFF, 23'd0};
      3: return {s, 8'hFF, f | 23'd1};
      4: ee = $urandom_range(250, 254);
      5, 6, 7: begin
        ee = int'(r[30:23]) + $urandom_range(0, 4) - 2;
        if (ee < 1) ee = 1;
        if (ee > 254) ee = 254;
      end
      8: return r ^ 32'h80000000;
      default: ;
    endcase
    return {s, 8'(ee), f};
  endfunction

  // Monitor: records expected results at accept and actual results at
  // transfer out; inputs only change at posedge+1, so negedge is stable.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) exp_q.push_back(ref_add(op_a, op_b));
      if (out_valid && out_ready) got_q.push_back({sum, ovf, invalid});
    end
  end

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    logic acc;
    acc = 1'b0;
    op_a = a; op_b = b; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) break;
    end
    in_valid = 1'b0;
    chk("accept", 34'(acc), 34'd1);
  endtask

  task automatic one(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] es, input logic eo, input logic ei);
    got_q.delete(); exp_q.delete();
    send(a, b);
    for (int i = 0; i < 20 && got_q.size() == 0; i++) begin @(negedge clk); #1; end
    chk({tag, "_cnt"}, 34'(got_q.size()), 34'd1);
    if (got_q.size() != 0) chk(tag, got_q.pop_front(), {es, eo, ei});
    @(posedge clk); #1;
    got_q.delete(); exp_q.delete();
  endtask

  task automatic drain(input string tag, input int n);
    for (int i = 0; i < 300 && got_q.size() < exp_q.size(); i++) begin @(negedge clk); #1; end
    repeat (6) begin @(negedge clk); #1; end
    chk({tag, "_cnt"}, 34'(got_q.size()), 34'(n));
    while (got_q.size() != 0 && exp_q.size() != 0)
      chk(tag, got_q.pop_front(), exp_q.pop_front());
    @(posedge clk); #1;
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out", {sum, ovf, invalid}, 34'd0);
    chk("rst_vld", 34'(out_valid), 34'd0);
    chk("rst_rdy", 34'(in_ready), 34'd1);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // 1) Latency: accepted in cycle 0, visible in cycle 3
    got_q.delete(); exp_q.delete();
    op_a = 32'h3F800000; op_b = 32'h3F800000; in_valid = 1'b1;
    @(negedge clk); chk("lat_rdy", 34'(in_ready), 34'd1);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk); chk("lat_c1", 34'(out_valid), 34'd0);
    @(posedge clk); @(negedge clk); chk("lat_c2", 34'(out_valid), 34'd0);
    @(posedge clk); @(negedge clk);
    chk("lat_c3", {1'b0, out_valid, sum}, {1'b0, 1'b1, 32'h40000000});
    @(posedge clk); #1;
    got_q.delete(); exp_q.delete();

    // 2) Zero rules
    one("cancel",  32'h3F800000, 32'hBF800000, 32'h00000000, 1'b0, 1'b0);
    one("negzero", 32'h80000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0);
    one("ftz_in",  32'h00000001, 32'h00000000, 32'h00000000, 1'b0, 1'b0);
    one("norm",    32'h40400000, 32'hC0000000, 32'h3F800000, 1'b0, 1'b0);
    one("swap",    32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);

    // 3) Specials
    one("inf_ninf", 32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 1'b1);
    one("nan_in",   32'h7FA00000, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b1);
    one("inf_fin",  32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0, 1'b0);

    // 4) Overflow and rounding boundaries
`ifdef FP32_ADD_RNE_EN
    one("ovf",     32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 1'b0);
    one("rnd_up",  32'h3F800000, 32'h33C00000, 32'h3F800001, 1'b0, 1'b0);
`else
    one("ovf",     32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, 1'b0);
    one("rnd_up",  32'h3F800000, 32'h33C00000, 32'h3F800000, 1'b0, 1'b0);
`endif
    one("rnd_tie", 32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0, 1'b0);

    // 5) Six back-to-back pairs with a 5-cycle output stall mid-stream
    got_q.delete(); exp_q.delete();
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          ra = rnd_fp(32'h3F800000);
          rb = rnd_fp(ra);
          send(ra, rb);
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1; out_ready = 1'b0;
        @(negedge clk); held = sum;
        for (int c = 0; c < 5; c++) begin
          if (c != 0) @(negedge clk);
          chk("stall_vld", 34'(out_valid), 34'd1);
          chk("stall_rdy", 34'(in_ready), 34'd0);
          chk("stall_sum", {2'b00, sum}, {2'b00, held});
        end
        @(posedge clk); #1; out_ready = 1'b1;
      end
    join
    drain("stream", 6);

    // Randomized stream with random back-pressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          ra = rnd_fp(32'h40490FDB);
          rb = rnd_fp(ra);
          send(ra, rb);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain("rand", 200);

    // 6) Reset with three items in flight
    got_q.delete(); exp_q.delete();
    send(32'h7F800000, 32'hFF800000);
    send(32'h3F800000, 32'h3F800000);
    send(32'h7F7FFFFF, 32'h7F7FFFFF);
    chk("rst_pre", {sum, ovf, invalid}, {32'h7FC00000, 2'b01});
    rst_n = 1'b0; #1;
    chk("rst_mid_out", {sum, ovf, invalid}, 34'd0);
    chk("rst_mid_vld", 34'(out_valid), 34'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin @(negedge clk); seen = seen | out_valid; end
    chk("rst_quiet", 34'(seen), 34'd0);
    @(posedge clk); #1;
    got_q.delete(); exp_q.delete();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
